// File: rtl/mux_nto1_pipe.sv
// N-channel valid/ready selector with a single registered output stage.
// Optional round-robin arbiter is compiled in when MUX_NTO1_RR_EN is defined.
module mux_nto1_pipe #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int SEL_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH*WIDTH-1:0] in_data,
  input  logic [CH-1:0]       in_valid,
  output logic [CH-1:0]       in_ready,
  input  logic [SEL_W-1:0]    sel,
  input  logic                sel_mode,
  output logic [WIDTH-1:0]    out_data,
  output logic [SEL_W-1:0]    out_ch,
  output logic                out_valid,
  input  logic                out_ready
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;

  logic             load;
  logic             ex_any;
  logic             grant_any;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;

  assign load = !out_valid_q || out_ready;

  // Explicit grant: sel must name an existing channel that is valid.
  always_comb begin
    ex_any = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (sel == SEL_W'(i) && in_valid[i]) ex_any = 1'b1;
    end
  end

`ifdef MUX_NTO1_RR_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             rr_any, hi_any, lo_any;
  logic [SEL_W-1:0] rr_idx, hi_idx, lo_idx;

  // Lowest valid index at or above ptr wins; otherwise wrap to lowest valid overall.
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        lo_any = 1'b1;
        lo_idx = SEL_W'(i);
        if (i >= int'(ptr_q)) begin
          hi_any = 1'b1;
          hi_idx = SEL_W'(i);
        end
      end
    end
    rr_any = hi_any || lo_any;
    rr_idx = hi_any ? hi_idx : lo_idx;
  end

  always_comb begin
    if (sel_mode) begin
      grant_any = rr_any;
      grant_idx = rr_idx;
    end else begin
      grant_any = ex_any;
      grant_idx = sel;
    end
  end
`else
  logic unused_sel_mode;
  assign unused_sel_mode = sel_mode;

  always_comb begin
    grant_any = ex_any;
    grant_idx = sel;
  end
`endif

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CH; i++) begin
      if (grant_idx == SEL_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ready
      assign in_ready[gi] = load && grant_any && (grant_idx == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
`ifdef MUX_NTO1_RR_EN
    ptr_d       = ptr_q;
`endif
    if (load) begin
      out_valid_d = grant_any;
      if (grant_any) begin
        out_data_d = grant_data;
        out_ch_d   = grant_idx;
`ifdef MUX_NTO1_RR_EN
        if (sel_mode) begin
          ptr_d = (grant_idx == SEL_W'(CH - 1)) ? '0 : grant_idx + SEL_W'(1);
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
`ifdef MUX_NTO1_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
`ifdef MUX_NTO1_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule
